speed_gate_ctrl: RTL and testbench

Measurement sequencer for the speedometer datapath. It opens a fixed-length gate window, counts rising edges of the wheel-sensor pulse inside that window, and latches the count as the speed sample for the display path. It runs single-shot or back-to-back windows, and no sensor edge is lost between consecutive windows.

---
 rtl/velo_pkg.sv | 16 +
 rtl/pulse_edge_sync.sv | 70 +++++++
 rtl/speed_gate_ctrl.sv | 121 ++++++++++++
 tb/tb_speed_gate_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/velo_pkg.sv
// Shared definitions for the speedometer datapath: FSM state encoding and
// default sizing for the 50 MHz board clock.
package velo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GATE  = 2'd1,
        LATCH = 2'd2
    } gate_state_e;

    localparam int CLK_HZ          = 50_000_000;
    localparam int GATE_CYCLES_DEF = CLK_HZ;      // one-second window
    localparam int CNT_W_DEF       = 16;
    localparam int DEB_CYCLES_DEF  = 4;

endpackage

// File: rtl/pulse_edge_sync.sv
// Wheel-sensor conditioning: 2-FF synchronizer, optional debounce filter
// (compiled in with SPEED_DEBOUNCE_EN), and registered rising-edge strobe.
module pulse_edge_sync #(
    parameter int DEB_CYCLES = 4
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic Pulse,
    output logic edge_stb
);

    logic sync1;
    logic sync2;
    logic lvl;
    logic lvl_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its source, which is what makes a chain.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= Pulse;
            sync2 <= sync1;
        end
    end

`ifdef SPEED_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic [DEB_W-1:0] deb_cnt;
    logic             filt;

    // The filtered level only follows sync2 after DEB_CYCLES samples in a row
    // disagree with it; any agreeing sample restarts the run.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            deb_cnt <= '0;
            filt    <= 1'b0;
        end else if (sync2 != filt) begin
            if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                filt    <= sync2;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end else begin
            deb_cnt <= '0;
        end
    end

    assign lvl = filt;
`else
    localparam int unused_deb_cycles = DEB_CYCLES;

    assign lvl = sync2;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            lvl_q    <= 1'b0;
            edge_stb <= 1'b0;
        end else begin
            lvl_q    <= lvl;
            edge_stb <= lvl & ~lvl_q;
        end
    end

endmodule

// File: rtl/speed_gate_ctrl.sv
// Speed measurement sequencer: counts conditioned sensor edges over a fixed
// gate window and latches the result. Debounce is selected by SPEED_DEBOUNCE_EN.
module speed_gate_ctrl
    import velo_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEB_CYCLES  = DEB_CYCLES_DEF
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             Cont,
    input  logic             Pulse,
    output logic [CNT_W-1:0] Speed,
    output logic             Valid,
    output logic             Ovf,
    output logic             Busy
);

    localparam int                TMR_W    = $clog2(GATE_CYCLES);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    gate_state_e       state_q, state_d;
    logic [TMR_W-1:0]  tmr_q,   tmr_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              sat_q,   sat_d;
    logic [CNT_W-1:0]  speed_q, speed_d;
    logic              ovf_q,   ovf_d;
    logic              valid_q, valid_d;
    logic              edge_stb;

    pulse_edge_sync #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_sync (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Pulse    (Pulse),
        .edge_stb (edge_stb)
    );

    always_comb begin
        // NOTE: every target is given its hold value first, so no branch can
        // leave one unassigned and infer a latch.
        state_d = state_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        speed_d = speed_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Start || Cont) begin
                    state_d = GATE;
                    tmr_d   = TMR_LOAD;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end

            GATE: begin
                if (edge_stb) begin
                    if (cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                if (tmr_q == '0) begin
                    state_d = LATCH;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end

            LATCH: begin
                speed_d = cnt_q;
                ovf_d   = sat_q;
                valid_d = 1'b1;
                // An edge landing in LATCH opens the next window's count.
                cnt_d   = CNT_W'(edge_stb);
                sat_d   = 1'b0;
                tmr_d   = TMR_LOAD;
                state_d = Cont ? GATE : IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            speed_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            speed_q <= speed_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign Speed = speed_q;
    assign Valid = valid_q;
    assign Ovf   = ovf_q;
    assign Busy  = (state_q != IDLE);

endmodule

// File: tb/tb_speed_gate_ctrl.sv
// Bench for speed_gate_ctrl: two instances (4-bit and 2-bit counters) share
// directed stimulus and are compared every cycle against a window-level model.
module tb_speed_gate_ctrl;

    localparam int G   = 10;
    localparam int DEB = 4;

    logic       Clk   = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Start = 1'b0;
    logic       Cont  = 1'b0;
    logic       Pulse = 1'b0;

    logic [3:0] speed_a;
    logic       valid_a, ovf_a, busy_a;
    logic [1:0] speed_b;
    logic       valid_b, ovf_b, busy_b;

    speed_gate_ctrl #(.GATE_CYCLES(G), .CNT_W(4), .DEB_CYCLES(DEB)) dut_a (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Cont(Cont), .Pulse(Pulse),
        .Speed(speed_a), .Valid(valid_a), .Ovf(ovf_a), .Busy(busy_a)
    );

    speed_gate_ctrl #(.GATE_CYCLES(G), .CNT_W(2), .DEB_CYCLES(DEB)) dut_b (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Cont(Cont), .Pulse(Pulse),
        .Speed(speed_b), .Valid(valid_b), .Ovf(ovf_b), .Busy(busy_b)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: pulse samples per clock, derived sensor edges, windows as
    // [start+1 .. start+G] plus a latch clock, unbounded count clamped on output.
    bit ph[4096];
    bit fl[4096];
    bit m_busy  = 1'b0;
    bit m_valid = 1'b0;
    int m_end   = 0;
    int m_cnt   = 0;
    int m_lat   = 0;

    function automatic bit filt_next(input int tt);
        for (int k = 2; k <= DEB + 1; k++)
            if (ph[tt-k] == fl[tt-1]) return fl[tt-1];
        return !fl[tt-1];
    endfunction

    function automatic bit edge_at(input int tt);
`ifdef SPEED_DEBOUNCE_EN
        if (tt < 3) return 1'b0;
        return fl[tt-2] && !fl[tt-3];
`else
        if (tt < 4) return 1'b0;
        return ph[tt-3] && !ph[tt-4];
`endif
    endfunction

    always @(posedge Clk) begin : model
        bit e;
        if (!Rst_n) begin
            ph[cyc] = 1'b0;
            fl[cyc] = 1'b0;
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_cnt   = 0;
            m_lat   = 0;
        end else begin
            ph[cyc] = Pulse;
            fl[cyc] = (cyc > DEB) ? filt_next(cyc) : 1'b0;
            e       = edge_at(cyc);
            m_valid = 1'b0;
            if (!m_busy) begin
                if (Start || Cont) begin
                    m_busy = 1'b1;
                    m_end  = cyc + G;
                    m_cnt  = 0;
                end
            end else if (cyc <= m_end) begin
                m_cnt += int'(e);
            end else begin
                m_valid = 1'b1;
                m_lat   = m_cnt;
                if (Cont) begin
                    m_end = cyc + G;
                    m_cnt = int'(e);
                end else begin
                    m_busy = 1'b0;
                end
            end
        end
        cyc++;
    end

    always @(negedge Clk) begin
        check("valid_a", valid_a, m_valid);
        check("speed_a", speed_a, (m_lat > 15) ? 15 : m_lat);
        check("ovf_a",   ovf_a,   m_lat > 15);
        check("busy_a",  busy_a,  m_busy);
        check("valid_b", valid_b, m_valid);
        check("speed_b", speed_b, (m_lat > 3) ? 3 : m_lat);
        check("ovf_b",   ovf_b,   m_lat > 3);
        check("busy_b",  busy_b,  m_busy);
    end

    int v_cnt = 0;
    int v_sum = 0;
    always @(negedge Clk) begin
        if (valid_a === 1'b1) begin
            v_cnt++;
            v_sum += int'(speed_a);
        end
    end

    // One clock of stimulus: inputs held across the next rising edge.
    task automatic cyc1(input logic s, input logic c, input logic p);
        Start = s;
        Cont  = c;
        Pulse = p;
        @(negedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc1(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish within 100us");
        $fatal(1);
    end

    initial begin
        idle(2);
        check("rst_speed", speed_a, 0);
        check("rst_valid", valid_a, 0);
        check("rst_ovf",   ovf_a,   0);
        check("rst_busy",  busy_a,  0);
        Rst_n = 1'b1;
        idle(4);

`ifdef SPEED_DEBOUNCE_EN
        for (int j = 0; j <= 13; j++) begin
            cyc1(j == 0, 1'b0, (j == 1 || j == 2));
            if (j == 11) begin
                check("deb_glitch_valid", valid_a, 1);
                check("deb_glitch_speed", speed_a, 0);
            end
        end
        idle(4);
        for (int j = 0; j <= 13; j++) begin
            cyc1(j == 0, 1'b0, (j >= 1 && j <= 6));
            if (j == 11) begin
                check("deb_pulse_valid", valid_a, 1);
                check("deb_pulse_speed", speed_a, 1);
            end
        end
        idle(4);
`else
        // Single shot, three clean pulses.
        v_cnt = 0; v_sum = 0;
        cyc1(1, 0, 1); cyc1(0, 0, 0); cyc1(0, 0, 1); cyc1(0, 0, 0); cyc1(0, 0, 1);
        idle(6);
        check("t1_valid_early", valid_a, 0);
        check("t1_busy_early",  busy_a,  1);
        idle(1);
        check("t1_valid", valid_a, 1);
        check("t1_speed", speed_a, 3);
        check("t1_ovf",   ovf_a,   0);
        check("t1_busy",  busy_a,  0);
        idle(3);
        check("t1_valid_count", v_cnt, 1);

        // Continuous windows, one pulse every two clocks, Cont dropped mid-window.
        idle(4);
        v_cnt = 0; v_sum = 0;
        for (int j = -2; j <= 36; j++) begin
            cyc1(1'b0, (j >= 0 && j <= 24), (j <= 28 && (j % 2 == 0)));
            if (j == 11) check("t2_w1_speed", speed_a, 5);
            if (j == 12) check("t2_w1_valid_gap", valid_a, 0);
            if (j == 22) check("t2_w2_speed", speed_a, 6);
            if (j == 33) check("t2_w3_speed", speed_a, 5);
            if (j == 34) check("t2_busy_end", busy_a, 0);
        end
        check("t2_valid_count", v_cnt, 3);
        check("t2_total_edges", v_sum, 16);

        // Saturation on the 2-bit instance, then a clean follow-up window.
        idle(4);
        for (int j = -2; j <= 23; j++) begin
            cyc1((j == 0 || j == 12), 1'b0, ((j <= 6 && j % 2 == 0) || j == 13));
            if (j == 11) begin
                check("t3_sat_speed_b", speed_b, 3);
                check("t3_sat_ovf_b",   ovf_b,   1);
                check("t3_sat_speed_a", speed_a, 5);
                check("t3_sat_ovf_a",   ovf_a,   0);
            end
            if (j == 23) begin
                check("t3_next_speed_b", speed_b, 1);
                check("t3_next_ovf_b",   ovf_b,   0);
            end
        end

        // Reset in the middle of a window.
        idle(4);
        v_cnt = 0; v_sum = 0;
        for (int j = 0; j <= 5; j++) cyc1(j == 0, 1'b0, (j == 0 || j == 2));
        check("t4_busy_pre", busy_a, 1);
        #1 Rst_n = 1'b0;
        #1;
        check("t4_rst_speed_a", speed_a, 0);
        check("t4_rst_speed_b", speed_b, 0);
        check("t4_rst_valid",   valid_a, 0);
        check("t4_rst_busy",    busy_a,  0);
        idle(2);
        Rst_n = 1'b1;
        idle(12);
        check("t4_no_valid", v_cnt, 0);
        for (int j = 0; j <= 13; j++) begin
            cyc1(j == 0, 1'b0, (j == 0 || j == 2));
            if (j == 11) begin
                check("t4_fresh_valid", valid_a, 1);
                check("t4_fresh_speed", speed_a, 2);
            end
        end

        // Start+Cont together in IDLE, then a Start during GATE.
        idle(4);
        v_cnt = 0; v_sum = 0;
        for (int j = 0; j <= 20; j++) begin
            cyc1((j == 0 || j == 4), (j == 0), (j == 1));
            if (j == 11) check("t5_speed", speed_a, 1);
        end
        check("t5_valid_count", v_cnt, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
